// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode patterns, ALU operation codes and per-stage control bundles
// for the in-order pipeline controller.
package pipe_ctrl_pkg;

    localparam int NREG_W  = 5;
    localparam int NFLAG_W = 4;

    // Opcode patterns over instruction bits [31:21]; mask bits at 0 are operand bits.
    localparam logic [10:0] OP_B_VAL     = 11'b000101_00000;
    localparam logic [10:0] OP_B_MSK     = 11'b111111_00000;
    localparam logic [10:0] OP_CBZ_VAL   = 11'b10110100_000;
    localparam logic [10:0] OP_BCOND_VAL = 11'b01010100_000;
    localparam logic [10:0] OP_CB_MSK    = 11'b11111111_000;
    localparam logic [10:0] OP_ADDS_VAL  = 11'b10101011000;
    localparam logic [10:0] OP_SUBS_VAL  = 11'b11101011000;
    localparam logic [10:0] OP_LDUR_VAL  = 11'b11111000010;
    localparam logic [10:0] OP_LDURB_VAL = 11'b00111000010;
    localparam logic [10:0] OP_STUR_VAL  = 11'b11111000000;
    localparam logic [10:0] OP_STURB_VAL = 11'b00111000000;
    localparam logic [10:0] OP_FULL_MSK  = 11'b11111111111;
    localparam logic [10:0] OP_ADDI_VAL  = 11'b1001000100_0;
    localparam logic [10:0] OP_ADDI_MSK  = 11'b1111111111_0;
    localparam logic [10:0] OP_MOVK_VAL  = 11'b111100101_00;
    localparam logic [10:0] OP_MOVZ_VAL  = 11'b110100101_00;
    localparam logic [10:0] OP_MOV_MSK   = 11'b111111111_00;

    typedef enum logic [2:0] {
        ALU_PASSB = 3'b000,
        ALU_ADD   = 3'b010,
        ALU_SUB   = 3'b011
    } alu_op_e;

    typedef struct packed {
        logic    ALUSrc;
        alu_op_e ALUOp;
        logic    ChooseImm;
        logic    ChooseMovk;
        logic    ChooseMovz;
        logic    storeFlags;
        logic    Reg2Loc;
    } ex_ctrl_t;

    typedef struct packed {
        logic MemWrite;
        logic MemRead;
        logic xferByte;
    } mem_ctrl_t;

    typedef struct packed {
        logic              RegWrite;
        logic              MemToReg;
        logic [NREG_W-1:0] rd;
    } wb_ctrl_t;

    // Full decode of one instruction: stage controls plus hazard/branch class bits.
    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        logic      RegWrite;
        logic      MemToReg;
        logic      is_b;
        logic      is_cbz;
        logic      is_blt;
        logic      is_load;
        logic      uses_rn;
        logic      uses_r2;
    } dec_t;

    function automatic logic op_match(input logic [10:0] op, input logic [10:0] val,
                                      input logic [10:0] msk);
        return (op & msk) == val;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction bits [31:21] to the full control
// bundle. Unknown opcodes and unused controls decode to zero.
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [10:0] i_opcode,
    output dec_t        o_dec
);

    always_comb begin
        o_dec = '0;
        if (op_match(i_opcode, OP_B_VAL, OP_B_MSK)) begin
            o_dec.is_b = 1'b1;
        end else if (op_match(i_opcode, OP_CBZ_VAL, OP_CB_MSK)) begin
            o_dec.is_cbz   = 1'b1;
            o_dec.uses_r2  = 1'b1;
            o_dec.ex.ALUOp = ALU_PASSB;
        end else if (op_match(i_opcode, OP_BCOND_VAL, OP_CB_MSK)) begin
            o_dec.is_blt = 1'b1;
        end else if (op_match(i_opcode, OP_ADDS_VAL, OP_FULL_MSK) ||
                     op_match(i_opcode, OP_SUBS_VAL, OP_FULL_MSK)) begin
            o_dec.ex.ALUOp      = i_opcode[9] ? ALU_SUB : ALU_ADD;
            o_dec.ex.storeFlags = 1'b1;
            o_dec.ex.Reg2Loc    = 1'b1;
            o_dec.RegWrite      = 1'b1;
            o_dec.uses_rn       = 1'b1;
            o_dec.uses_r2       = 1'b1;
        end else if (op_match(i_opcode, OP_ADDI_VAL, OP_ADDI_MSK)) begin
            o_dec.ex.ALUSrc    = 1'b1;
            o_dec.ex.ALUOp     = ALU_ADD;
            o_dec.ex.ChooseImm = 1'b1;
            o_dec.RegWrite     = 1'b1;
            o_dec.uses_rn      = 1'b1;
        end else if (op_match(i_opcode, OP_LDUR_VAL, OP_FULL_MSK) ||
                     op_match(i_opcode, OP_LDURB_VAL, OP_FULL_MSK)) begin
            o_dec.ex.ALUSrc     = 1'b1;
            o_dec.ex.ALUOp      = ALU_ADD;
            o_dec.mem.MemRead   = 1'b1;
            o_dec.mem.xferByte  = ~i_opcode[10];
            o_dec.MemToReg      = 1'b1;
            o_dec.RegWrite      = 1'b1;
            o_dec.is_load       = 1'b1;
            o_dec.uses_rn       = 1'b1;
        end else if (op_match(i_opcode, OP_STUR_VAL, OP_FULL_MSK) ||
                     op_match(i_opcode, OP_STURB_VAL, OP_FULL_MSK)) begin
            o_dec.ex.ALUSrc     = 1'b1;
            o_dec.ex.ALUOp      = ALU_ADD;
            o_dec.mem.MemWrite  = 1'b1;
            o_dec.mem.xferByte  = ~i_opcode[10];
            o_dec.uses_rn       = 1'b1;
            o_dec.uses_r2       = 1'b1;
        end else if (op_match(i_opcode, OP_MOVK_VAL, OP_MOV_MSK)) begin
            o_dec.ex.ChooseMovk = 1'b1;
            o_dec.RegWrite      = 1'b1;
            o_dec.uses_r2       = 1'b1;
        end else if (op_match(i_opcode, OP_MOVZ_VAL, OP_MOV_MSK)) begin
            o_dec.ex.ChooseMovz = 1'b1;
            o_dec.RegWrite      = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_control.sv
// Pipelined control unit: decodes in ID, carries control through EX/MEM/WB,
// resolves branches in EX and detects load-use hazards against the ID stage.
module pipe_control
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W  = NREG_W,
    parameter int FLAG_W = NFLAG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       opcode,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  rd_id,
    input  logic [REG_W-1:0]  rn_id,
    input  logic [REG_W-1:0]  rm_id,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              alu_zero,
    output ex_ctrl_t          ex_ctrl,
    output mem_ctrl_t         mem_ctrl,
    output wb_ctrl_t          wb_ctrl,
    output logic              br_taken,
    output logic              uncond_br,
    output logic              stall,
    output logic              flush,
    output logic [FLAG_W-1:0] flags
);

    localparam int STAGES = 3;  // 1=EX, 2=MEM, 3=WB
    localparam logic [REG_W-1:0] XZR = '1;

    dec_t              w_dec;
    wb_ctrl_t          w_id_wb;
    logic [REG_W-1:0]  w_src2;
    logic              w_load_use;
    logic              w_ex_accept;

    logic [STAGES:1]   r_vld_pipe;
    ex_ctrl_t          r_ex_ctrl;
    mem_ctrl_t         r_ex_mem;
    wb_ctrl_t          r_ex_wb;
    logic              r_ex_b, r_ex_cbz, r_ex_blt, r_ex_load;
    mem_ctrl_t         r_mem_ctrl;
    wb_ctrl_t          r_mem_wb;
    wb_ctrl_t          r_wb;
    logic [FLAG_W-1:0] r_flags;

    ctrl_decode u_decode (
        .i_opcode (opcode),
        .o_dec    (w_dec)
    );

    // Destination is only meaningful for register writers; others carry rd=0.
    always_comb begin
        w_id_wb          = '0;
        w_id_wb.RegWrite = w_dec.RegWrite;
        w_id_wb.MemToReg = w_dec.MemToReg;
        if (w_dec.RegWrite) w_id_wb.rd = rd_id;
    end

    assign w_src2     = w_dec.ex.Reg2Loc ? rm_id : rd_id;
    assign w_load_use = r_vld_pipe[1] && r_ex_load && (r_ex_wb.rd != XZR) && id_valid &&
                        ((w_dec.uses_rn && (rn_id == r_ex_wb.rd)) ||
                         (w_dec.uses_r2 && (w_src2 == r_ex_wb.rd)));

    // B.LT reads the architectural register: a flag-setter one slot ahead has already written it.
    assign br_taken  = r_vld_pipe[1] &&
                       (r_ex_b || (r_ex_cbz && alu_zero) ||
                        (r_ex_blt && (r_flags[FLAG_W-1] ^ r_flags[0])));
    assign uncond_br = r_vld_pipe[1] && r_ex_b;
    assign flush     = br_taken;
    assign stall     = w_load_use && !flush;

    assign w_ex_accept = id_valid && !stall && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_pipe <= '0;
            r_ex_ctrl  <= '0;
            r_ex_mem   <= '0;
            r_ex_wb    <= '0;
            r_ex_b     <= 1'b0;
            r_ex_cbz   <= 1'b0;
            r_ex_blt   <= 1'b0;
            r_ex_load  <= 1'b0;
            r_mem_ctrl <= '0;
            r_mem_wb   <= '0;
            r_wb       <= '0;
            r_flags    <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_ex_accept};
            if (w_ex_accept) begin
                r_ex_ctrl <= w_dec.ex;
                r_ex_mem  <= w_dec.mem;
                r_ex_wb   <= w_id_wb;
                r_ex_b    <= w_dec.is_b;
                r_ex_cbz  <= w_dec.is_cbz;
                r_ex_blt  <= w_dec.is_blt;
                r_ex_load <= w_dec.is_load;
            end else begin
                r_ex_ctrl <= '0;
                r_ex_mem  <= '0;
                r_ex_wb   <= '0;
                r_ex_b    <= 1'b0;
                r_ex_cbz  <= 1'b0;
                r_ex_blt  <= 1'b0;
                r_ex_load <= 1'b0;
            end
            r_mem_ctrl <= r_ex_mem;
            r_mem_wb   <= r_ex_wb;
            r_wb       <= r_mem_wb;
            if (r_vld_pipe[1] && r_ex_ctrl.storeFlags) r_flags <= alu_flags;
        end
    end

    assign ex_ctrl  = r_vld_pipe[1] ? r_ex_ctrl  : '0;
    assign mem_ctrl = r_vld_pipe[2] ? r_mem_ctrl : '0;
    assign wb_ctrl  = r_vld_pipe[3] ? r_wb       : '0;
    assign flags    = r_flags;

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: a per-instruction reference model predicts
// every output each cycle; a monitor compares on the falling edge.
module tb_pipe_control;
    import pipe_ctrl_pkg::*;

    typedef enum int {K_UNK, K_B, K_CBZ, K_BLT, K_ADDS, K_SUBS, K_ADDI,
                      K_LDUR, K_LDURB, K_STUR, K_STURB, K_MOVK, K_MOVZ} kind_e;

    typedef struct {
        bit          vld;
        kind_e       kind;
        logic [10:0] op;
        logic [4:0]  rd, rn, rm;
        bit          zero;
        logic [3:0]  af;
        bit          rst;
    } rec_t;

    typedef struct {
        bit         v;
        kind_e      k;
        logic [4:0] rd;
    } slot_t;

    typedef struct {
        logic [8:0] ex;
        logic [2:0] mem;
        logic [6:0] wb;
        logic       br, ub, stall, flush;
        logic [3:0] flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] opcode = '0;
    logic        id_valid = 1'b0;
    logic [4:0]  rd_id = '0, rn_id = '0, rm_id = '0;
    logic [3:0]  alu_flags = '0;
    logic        alu_zero = 1'b0;
    ex_ctrl_t    ex_ctrl;
    mem_ctrl_t   mem_ctrl;
    wb_ctrl_t    wb_ctrl;
    logic        br_taken, uncond_br, stall, flush;
    logic [3:0]  flags;

    pipe_control #(.REG_W(5), .FLAG_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .id_valid(id_valid),
        .rd_id(rd_id), .rn_id(rn_id), .rm_id(rm_id),
        .alu_flags(alu_flags), .alu_zero(alu_zero),
        .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .br_taken(br_taken), .uncond_br(uncond_br), .stall(stall), .flush(flush),
        .flags(flags)
    );

    always #5 clk = ~clk;

    rec_t  prog[$];
    exp_t  sb[$];
    int    n_chk = 0, n_fail = 0, cyc = 0;
    rec_t  cur;
    slot_t s_ex, s_mem, s_wb;
    logic [3:0] m_flags;
    bit    m_stall, m_flush, hold;

    // Instruction encodings; operand bits inside the opcode field are randomised.
    function automatic logic [10:0] enc(kind_e k);
        logic [4:0] r = 5'($urandom);
        case (k)
            K_B:     return {6'b000101, r};
            K_CBZ:   return {8'b10110100, r[2:0]};
            K_BLT:   return {8'b01010100, r[2:0]};
            K_ADDS:  return 11'b10101011000;
            K_SUBS:  return 11'b11101011000;
            K_ADDI:  return {10'b1001000100, r[0]};
            K_LDUR:  return 11'b11111000010;
            K_LDURB: return 11'b00111000010;
            K_STUR:  return 11'b11111000000;
            K_STURB: return 11'b00111000000;
            K_MOVK:  return {9'b111100101, r[1:0]};
            K_MOVZ:  return {9'b110100101, r[1:0]};
            default: return 11'h000;
        endcase
    endfunction

    // {ALUSrc, ALUOp[2:0], ChooseImm, ChooseMovk, ChooseMovz, storeFlags, Reg2Loc}
    function automatic logic [8:0] ex_bits(kind_e k);
        case (k)
            K_ADDS:                           return 9'b0_010_0_0_0_1_1;
            K_SUBS:                           return 9'b0_011_0_0_0_1_1;
            K_ADDI:                           return 9'b1_010_1_0_0_0_0;
            K_LDUR, K_LDURB, K_STUR, K_STURB: return 9'b1_010_0_0_0_0_0;
            K_MOVK:                           return 9'b0_000_0_1_0_0_0;
            K_MOVZ:                           return 9'b0_000_0_0_1_0_0;
            default:                          return 9'b0;
        endcase
    endfunction

    // {MemWrite, MemRead, xferByte}
    function automatic logic [2:0] mem_bits(kind_e k);
        case (k)
            K_LDUR:  return 3'b010;
            K_LDURB: return 3'b011;
            K_STUR:  return 3'b100;
            K_STURB: return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit is_load(kind_e k);
        return k inside {K_LDUR, K_LDURB};
    endfunction

    function automatic bit writes(kind_e k);
        return k inside {K_ADDS, K_SUBS, K_ADDI, K_LDUR, K_LDURB, K_MOVK, K_MOVZ};
    endfunction

    function automatic bit reads_reg(rec_t r, logic [4:0] t);
        bit hit = 0;
        if (r.kind inside {K_ADDS, K_SUBS, K_ADDI, K_LDUR, K_LDURB, K_STUR, K_STURB})
            hit |= (r.rn == t);
        if (r.kind inside {K_ADDS, K_SUBS}) hit |= (r.rm == t);
        if (r.kind inside {K_STUR, K_STURB, K_CBZ, K_MOVK}) hit |= (r.rd == t);
        return hit;
    endfunction

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd1;
            1: return 5'd2;
            2: return 5'd5;
            default: return 5'd31;
        endcase
    endfunction

    task automatic add(kind_e k, bit v, logic [4:0] rd, logic [4:0] rn, logic [4:0] rm,
                       bit z, logic [3:0] af, bit rst);
        rec_t r;
        r.vld = v; r.kind = k; r.op = enc(k); r.rd = rd; r.rn = rn; r.rm = rm;
        r.zero = z; r.af = af; r.rst = rst;
        prog.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL cyc=%0d %s: got %h expected %h", cyc, name, act, req);
        end
    endtask

    // Effect of one clock edge on the in-flight instruction window.
    task automatic model_edge();
        if (cur.rst) begin
            s_ex.v = 0; s_mem.v = 0; s_wb.v = 0; m_flags = '0;
        end else begin
            if (s_ex.v && s_ex.k inside {K_ADDS, K_SUBS}) m_flags = cur.af;
            s_wb  = s_mem;
            s_mem = s_ex;
            s_ex.v = cur.vld && !m_stall && !m_flush;
            s_ex.k = cur.kind;
            s_ex.rd = cur.rd;
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        e.ex    = s_ex.v  ? ex_bits(s_ex.k)   : '0;
        e.mem   = s_mem.v ? mem_bits(s_mem.k) : '0;
        e.wb    = (s_wb.v && writes(s_wb.k)) ? {1'b1, is_load(s_wb.k), s_wb.rd} : '0;
        e.ub    = s_ex.v && s_ex.k == K_B;
        e.br    = s_ex.v && (s_ex.k == K_B || (s_ex.k == K_CBZ && cur.zero) ||
                             (s_ex.k == K_BLT && (m_flags[3] ^ m_flags[0])));
        e.flush = e.br;
        e.stall = !e.flush && cur.vld && s_ex.v && is_load(s_ex.k) && s_ex.rd != 5'd31 &&
                  reads_reg(cur, s_ex.rd);
        e.flags = m_flags;
        return e;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("ex_ctrl",   {23'b0, ex_ctrl},  {23'b0, e.ex});
                check("mem_ctrl",  {29'b0, mem_ctrl}, {29'b0, e.mem});
                check("wb_ctrl",   {25'b0, wb_ctrl},  {25'b0, e.wb});
                check("br_taken",  {31'b0, br_taken}, {31'b0, e.br});
                check("uncond_br", {31'b0, uncond_br}, {31'b0, e.ub});
                check("stall",     {31'b0, stall},    {31'b0, e.stall});
                check("flush",     {31'b0, flush},    {31'b0, e.flush});
                check("flags",     {28'b0, flags},    {28'b0, e.flags});
            end
        end
    end

    initial begin : driver
        rec_t r;
        exp_t e;
        // Directed: reset, flag setters, load-use, XZR load, CBZ both ways, B.LT, unknown, reset in stall.
        add(K_UNK,  1, 0, 0, 0, 0, 4'h0, 1);
        add(K_UNK,  1, 0, 0, 0, 0, 4'h0, 1);
        add(K_ADDS, 1, 1, 2, 3, 0, 4'h0, 0);
        add(K_SUBS, 1, 4, 1, 2, 0, 4'b0001, 0);
        add(K_LDUR, 1, 5, 6, 0, 0, 4'b1000, 0);
        add(K_ADDS, 1, 7, 8, 5, 0, 4'h0, 0);
        add(K_ADDI, 1, 9, 9, 9, 0, 4'h0, 0);
        add(K_LDUR, 1, 31, 1, 0, 0, 4'h0, 0);
        add(K_ADDS, 1, 2, 31, 31, 0, 4'h0, 0);
        add(K_CBZ,  1, 2, 0, 0, 0, 4'h0, 0);
        add(K_MOVZ, 1, 3, 0, 0, 1, 4'h0, 0);
        add(K_CBZ,  1, 3, 0, 0, 0, 4'h0, 0);
        add(K_ADDI, 1, 4, 4, 4, 0, 4'h0, 0);
        add(K_SUBS, 1, 1, 2, 3, 0, 4'h0, 0);
        add(K_BLT,  1, 0, 0, 0, 0, 4'b1000, 0);
        add(K_MOVK, 1, 1, 0, 0, 0, 4'h0, 0);
        add(K_UNK,  1, 0, 0, 0, 0, 4'h0, 0);
        add(K_ADDS, 1, 1, 1, 1, 0, 4'h0, 0);
        add(K_LDUR, 1, 5, 6, 0, 0, 4'h0, 0);
        add(K_ADDS, 1, 7, 8, 5, 0, 4'h0, 1);
        add(K_MOVZ, 1, 2, 0, 0, 0, 4'h0, 0);
        add(K_B,    1, 0, 0, 0, 0, 4'h0, 0);
        add(K_STUR, 1, 2, 2, 0, 0, 4'h0, 0);
        for (int i = 0; i < 1500; i++) begin
            r.kind = kind_e'($urandom_range(0, 12));
            r.op   = enc(r.kind);
            if (r.kind == K_UNK && $urandom_range(0, 1) == 1) r.op = 11'h7FF;
            r.vld  = ($urandom_range(0, 99) < 85);
            r.rd   = pick_reg(); r.rn = pick_reg(); r.rm = pick_reg();
            r.zero = 1'($urandom);
            r.af   = 4'($urandom);
            r.rst  = ($urandom_range(0, 99) < 2);
            prog.push_back(r);
        end

        cur = '{vld: 0, kind: K_UNK, op: 11'h0, rd: 0, rn: 0, rm: 0, zero: 0, af: 0, rst: 1};
        m_flags = '0; m_stall = 0; m_flush = 0; hold = 0;
        s_ex = '{v: 0, k: K_UNK, rd: 0}; s_mem = s_ex; s_wb = s_ex;

        while (prog.size() != 0) begin
            @(posedge clk);
            model_edge();
            #1;
            cyc++;
            r = prog.pop_front();
            if (hold) begin
                r.vld = cur.vld; r.kind = cur.kind; r.op = cur.op;
                r.rd = cur.rd; r.rn = cur.rn; r.rm = cur.rm;
            end
            cur = r;
            reset = cur.rst; id_valid = cur.vld; opcode = cur.op;
            rd_id = cur.rd; rn_id = cur.rn; rm_id = cur.rm;
            alu_zero = cur.zero; alu_flags = cur.af;
            e = predict();
            sb.push_back(e);
            m_stall = e.stall; m_flush = e.flush;
            hold = e.stall && !cur.rst;
        end
        repeat (2) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
